// File: rtl/cohort_fifo_ptr_engine.sv
// Multi-channel FIFO pointer engine: per-channel base/size/length/pointer
// with element address generation and full/empty against a peer pointer.
// Ports:
//   cfg_*  : config write handshake (cfg_err pulses on a rejected config)
//   adv_*  : per-element advance handshake (adv_err pulses on a disabled channel)
//   peer_ptr : per-channel peer pointer from the other side of the queue
//   addr_* : 1-deep registered element address output
//   own_ptr, ch_en, ch_full, ch_empty : per-channel status
module cohort_fifo_ptr_engine #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 64,
  parameter int PTR_W  = 32,
  parameter int SIZE_W = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_role,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [SIZE_W-1:0]       cfg_elem_size,
  input  logic [PTR_W-1:0]        cfg_length,
  input  logic [PTR_W-1:0]        cfg_ptr_init,
  output logic                    cfg_err,
  input  logic                    adv_valid,
  output logic                    adv_ready,
  input  logic [CH_W-1:0]         adv_ch,
  output logic                    adv_err,
  input  logic [NUM_CH*PTR_W-1:0] peer_ptr,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [ADDR_W-1:0]       addr,
  output logic [CH_W-1:0]         addr_ch,
  output logic [PTR_W-1:0]        addr_ptr,
  output logic [NUM_CH*PTR_W-1:0] own_ptr,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_full,
  output logic [NUM_CH-1:0]       ch_empty
);

  localparam int PW = PTR_W + SIZE_W;

  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] role_q;
  logic [ADDR_W-1:0] base_q [NUM_CH];
  logic [SIZE_W-1:0] size_q [NUM_CH];
  logic [PTR_W-1:0]  len_q  [NUM_CH];
  logic [PTR_W-1:0]  ptr_q  [NUM_CH];
  logic [PTR_W-1:0]  nxt    [NUM_CH];

  logic              blocked;
  logic              cfg_hit;
  logic              cfg_fire;
  logic              adv_fire;
  logic              cfg_bad;
  logic [PW-1:0]     prod;
  logic [ADDR_W-1:0] addr_calc;

  // Status: role 0 = producer (tail), role 1 = consumer (head).
  always_comb begin
    ch_full  = '0;
    ch_empty = '0;
    own_ptr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nxt[i] = (ptr_q[i] + PTR_W'(1) == len_q[i]) ?
               '0 : ptr_q[i] + PTR_W'(1);
      ch_full[i]  = en_q[i] & ~role_q[i] &
                    (nxt[i] == peer_ptr[i*PTR_W +: PTR_W]);
      ch_empty[i] = en_q[i] & role_q[i] &
                    (ptr_q[i] == peer_ptr[i*PTR_W +: PTR_W]);
      own_ptr[i*PTR_W +: PTR_W] = ptr_q[i];
    end
  end

  assign ch_en = en_q;

  assign blocked   = ch_full[adv_ch] | ch_empty[adv_ch];
  // A config to the channel being advanced takes priority.
  assign cfg_hit   = cfg_valid & (cfg_ch == adv_ch);
  assign cfg_ready = rst_n;
  assign adv_ready = rst_n & (~addr_valid | addr_ready) &
                     ~blocked & ~cfg_hit;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign adv_fire  = adv_valid & adv_ready;

  assign cfg_bad = (cfg_length == '0) | (cfg_elem_size == '0) |
                   (cfg_ptr_init >= cfg_length);

  assign prod      = PW'(ptr_q[adv_ch]) * PW'(size_q[adv_ch]);
  assign addr_calc = base_q[adv_ch] + ADDR_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q       <= '0;
      role_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
        len_q[i]  <= '0;
        ptr_q[i]  <= '0;
      end
      addr_valid <= 1'b0;
      addr       <= '0;
      addr_ch    <= '0;
      addr_ptr   <= '0;
      cfg_err    <= 1'b0;
      adv_err    <= 1'b0;
    end else begin
      cfg_err <= cfg_fire & cfg_bad;
      adv_err <= adv_fire & ~en_q[adv_ch];

      if (addr_valid & addr_ready)
        addr_valid <= 1'b0;

      if (adv_fire & en_q[adv_ch]) begin
        addr_valid    <= 1'b1;
        addr          <= addr_calc;
        addr_ch       <= adv_ch;
        addr_ptr      <= ptr_q[adv_ch];
        ptr_q[adv_ch] <= nxt[adv_ch];
      end

      if (cfg_fire) begin
        if (cfg_bad) begin
          en_q[cfg_ch]   <= 1'b0;
          role_q[cfg_ch] <= 1'b0;
          base_q[cfg_ch] <= '0;
          size_q[cfg_ch] <= '0;
          len_q[cfg_ch]  <= '0;
          ptr_q[cfg_ch]  <= '0;
        end else begin
          en_q[cfg_ch]   <= 1'b1;
          role_q[cfg_ch] <= cfg_role;
          base_q[cfg_ch] <= cfg_base;
          size_q[cfg_ch] <= cfg_elem_size;
          len_q[cfg_ch]  <= cfg_length;
          ptr_q[cfg_ch]  <= cfg_ptr_init;
        end
      end
    end
  end

endmodule
